regfile_read_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single 32-word register-file read port (the 32:1 32-bit word multiplexer) among `NREQ` requesters. It accepts read requests as a 5-bit register index and drives the multiplexer select from a register. It captures the multiplexer output and returns the word with the requester ID through a valid/ready response port. It sits between the CPU-side read clients (operand fetch, debug, etc.) and the register-file mux.

---
 rtl/regread_pkg.sv | 17 +
 rtl/regfile_read_arbiter_if.sv | 28 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/regfile_read_arbiter.sv | 78 +++++++
 tb/tb_regfile_read_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/regread_pkg.sv
// rtl/regread_pkg.sv - shared sizing constants and helpers for the register-file read arbiter
package regread_pkg;

  localparam int NREQ_DEF = 4;
  localparam int AW_DEF   = 5;
  localparam int DW_DEF   = 32;

  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Bit offset of requester idx's index inside the flat address bus
  function automatic int addr_lsb(input int idx, input int aw);
    return idx * aw;
  endfunction

endpackage

// File: rtl/regfile_read_arbiter_if.sv
// rtl/regfile_read_arbiter_if.sv - request, mux and response signals of the shared register-file read port
interface regfile_read_arbiter_if import regread_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
);
  localparam int IDW = id_width(NREQ);

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ-1:0]    gnt;
  logic [AW-1:0]      sel;
  logic [DW-1:0]      mux_y;
  logic               rvalid;
  logic               rready;
  logic [DW-1:0]      rdata;
  logic [IDW-1:0]     rid;

  modport master (
    output req, addr, mux_y, rready,
    input  gnt, sel, rvalid, rdata, rid
  );

  modport slave (
    input  req, addr, mux_y, rready,
    output gnt, sel, rvalid, rdata, rid
  );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            valid
);

  // Scan offsets k = 0..NREQ-1 from ptr; the first requesting slot wins
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (en && !valid && req[i] && (((int'(ptr) + k) % NREQ) == i)) begin
          gnt[i] = 1'b1;
          idx    = IDW'(i);
          valid  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// rtl/regfile_read_arbiter.sv - shares the register-file read mux among NREQ requesters, latency 2
module regfile_read_arbiter import regread_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  parameter int IDW  = id_width(NREQ)
) (
  input logic                   clk,
  input logic                   rst_n,
  regfile_read_arbiter_if.slave bus
);

  logic            stall;
  logic            arb_en;
  logic            any_gnt;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gidx;
  logic [AW-1:0]   gaddr;

  logic [IDW-1:0]  ptr;
  logic [AW-1:0]   sel_q;
  logic            s1_valid;
  logic [IDW-1:0]  s1_id;
  logic            rvalid_q;
  logic [DW-1:0]   rdata_q;
  logic [IDW-1:0]  rid_q;

  assign stall  = rvalid_q & ~bus.rready;
  assign arb_en = rst_n & ~stall;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req   (bus.req),
    .ptr   (ptr),
    .en    (arb_en),
    .gnt   (gnt),
    .idx   (gidx),
    .valid (any_gnt)
  );

  assign gaddr = bus.addr[addr_lsb(int'(gidx), AW) +: AW];

  // The whole pipeline freezes on stall so sel, and hence mux_y, stays put
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      sel_q    <= '0;
      s1_valid <= 1'b0;
      s1_id    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rid_q    <= '0;
    end else if (!stall) begin
      if (any_gnt) begin
        sel_q    <= gaddr;
        s1_id    <= gidx;
        s1_valid <= 1'b1;
        ptr      <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
      end else begin
        s1_valid <= 1'b0;
      end
      rvalid_q <= s1_valid;
      if (s1_valid) begin
        rdata_q <= bus.mux_y;
        rid_q   <= s1_id;
      end
    end
  end

  assign bus.gnt    = gnt;
  assign bus.sel    = sel_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign bus.rid    = rid_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// tb/tb_regfile_read_arbiter.sv - directed and random checks of regfile_read_arbiter against a queue model
module tb_regfile_read_arbiter;
  import regread_pkg::*;

  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_read_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  regfile_read_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] mem [32];
  assign bus.mux_y = mem[bus.sel];

  typedef struct {
    int            id;
    int            addr;
    int            age;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          q[$];
  int            m_ptr;
  int            m_sel;
  int            last_g;
  int            compared;
  int            mismatched;
  logic          req_r [NREQ];
  logic [AW-1:0] addr_r [NREQ];
  logic [DW-1:0] hold_data;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (m_ptr + k) % NREQ;
      if (req_r[j]) return j;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req[i]            = req_r[i];
      bus.addr[i*AW +: AW]  = addr_r[i];
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ptr = 0;
    m_sel = 0;
  endtask

  // One clock: check outputs against the model, then advance the model across the edge
  task automatic step();
    int g;
    bit vis;
    bit stl;
    drive();
    #1;
    vis = (q.size() > 0) && (q[0].age >= 2);
    stl = vis && !bus.rready;
    g   = (rst_n && !stl) ? pick() : -1;
    chk("gnt", bus.gnt, (g < 0) ? 0 : (1 << g));
    chk("rvalid", bus.rvalid, vis);
    chk("sel", bus.sel, m_sel);
    if (vis) begin
      chk("rdata", bus.rdata, q[0].data);
      chk("rid", bus.rid, q[0].id);
    end
    last_g = g;
    @(posedge clk);
    if (rst_n && !stl) begin
      if (vis) void'(q.pop_front());
      foreach (q[k]) begin
        q[k].age++;
        if (q[k].age == 2) q[k].data = mem[q[k].addr];
      end
      if (g >= 0) begin
        q.push_back('{id: g, addr: int'(addr_r[g]), age: 1, data: '0});
        m_sel = int'(addr_r[g]);
        m_ptr = (g + 1) % NREQ;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int exp_wrap [3];
    compared   = 0;
    mismatched = 0;
    last_g     = -1;
    exp_wrap   = '{1, 4, 1};
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    for (int i = 0; i < NREQ; i++) begin
      req_r[i]  = 1'b0;
      addr_r[i] = '0;
    end
    bus.rready = 1'b1;
    drive();
    model_reset();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_sel", bus.sel, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_rid", bus.rid, 0);
    rst_n = 1'b1;

    // Single read from requester 2
    mem[17]   = 32'hA5A5_0011;
    req_r[2]  = 1'b1;
    addr_r[2] = 5'd17;
    drive();
    #1 chk("single_gnt", bus.gnt, 4'b0100);
    step();
    req_r[2] = 1'b0;
    chk("single_sel", bus.sel, 17);
    step();
    chk("single_rvalid", bus.rvalid, 1);
    chk("single_rdata", bus.rdata, 32'hA5A5_0011);
    chk("single_rid", bus.rid, 2);

    // Wrap and skip from ptr=3
    req_r[0] = 1'b1; addr_r[0] = 5'd4;
    req_r[2] = 1'b1; addr_r[2] = 5'd6;
    for (int k = 0; k < 3; k++) begin
      drive();
      #1 chk("wrap_gnt", bus.gnt, exp_wrap[k]);
      step();
    end

    // Reset asserted mid-stream with all requesting
    for (int i = 0; i < NREQ; i++) begin
      req_r[i]  = 1'b1;
      addr_r[i] = AW'(8 + i);
    end
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_gnt", bus.gnt, 0);
    chk("midrst_rvalid", bus.rvalid, 0);
    chk("midrst_sel", bus.sel, 0);
    chk("midrst_rdata", bus.rdata, 0);
    model_reset();
    step();
    rst_n = 1'b1;

    // Round-robin with everyone requesting
    for (int i = 0; i < 8; i++) begin
      drive();
      #1 chk("rr_gnt", bus.gnt, 1 << (i % NREQ));
      step();
    end
    for (int i = 0; i < NREQ; i++) req_r[i] = 1'b0;
    step();

    // Backpressure with a register-file write during the stall
    mem[3] = 32'h0000_0033;
    mem[9] = 32'h1;
    req_r[0] = 1'b1; addr_r[0] = 5'd3;
    req_r[1] = 1'b1; addr_r[1] = 5'd9;
    step();
    req_r[0] = 1'b0;
    step();
    req_r[1]   = 1'b0;
    bus.rready = 1'b0;
    mem[9]     = 32'h2;
    for (int k = 0; k < 3; k++) begin
      req_r[2] = 1'b1; addr_r[2] = 5'd1;
      step();
      chk("bp_gnt", bus.gnt, 0);
      chk("bp_rvalid", bus.rvalid, 1);
      chk("bp_rdata", bus.rdata, 32'h33);
      chk("bp_rid", bus.rid, 0);
      chk("bp_sel", bus.sel, 9);
    end
    bus.rready = 1'b1;
    step();
    chk("bp_second_rid", bus.rid, 1);
    chk("bp_second_rdata", bus.rdata, 32'h2);
    step();
    step();

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      if (last_g >= 0) begin
        req_r[last_g]  = 1'($urandom_range(0, 1));
        addr_r[last_g] = AW'($urandom_range(0, 31));
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!req_r[i] && $urandom_range(0, 3) == 0) begin
          req_r[i]  = 1'b1;
          addr_r[i] = AW'($urandom_range(0, 31));
        end
      end
      bus.rready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) mem[$urandom_range(0, 31)] = $urandom;
      step();
      if (bus.rvalid && !bus.rready) hold_data = bus.rdata;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
